// File: rtl/approx_pkg.sv
// Shared types and default parameters for the bit-serial approximate subtractor.
package approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_APPROX_BITS = 4;

endpackage

// File: rtl/approx_full_subtractor.sv
// Single-bit subtractor cell; approx_sel drops the b & bin term from the borrow.
module approx_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  input  logic approx_sel,
  output logic d,
  output logic bout
);

  logic bout_exact;
  logic bout_approx;

  assign d           = a ^ b ^ bin;
  assign bout_exact  = (~a & b) | (~a & bin) | (b & bin);
  assign bout_approx = ~a & (b | bin);
  assign bout        = approx_sel ? bout_approx : bout_exact;

endmodule

// File: rtl/approx_serial_subtractor.sv
// Bit-serial a - b, LSB first, one cell reused every cycle.
// Define APPROX_BORROW_EN to use the approximate borrow in the lowest APPROX_BITS bits.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one bit per cycle through the cell
// DONE  | result held until out_ready
module approx_serial_subtractor
  import approx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32 || APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_param
    $error("approx_serial_subtractor: illegal WIDTH/APPROX_BITS");
  end

  state_t          state;
  state_t          nstate;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             d_bit;
  logic             b_bit;
  logic             approx_sel;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

`ifdef APPROX_BORROW_EN
  localparam logic [CW:0] APPROX_LIM = (CW+1)'(APPROX_BITS);
  assign approx_sel = ({1'b0, cnt} < APPROX_LIM);
`else
  assign approx_sel = 1'b0;
`endif

  approx_full_subtractor u_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .bin        (borrow),
    .approx_sel (approx_sel),
    .d          (d_bit),
    .bout       (b_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = RUN;
      RUN:     if (last_bit) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Difference bits are shifted into the vacated MSBs of the minuend register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      cnt        <= '0;
      borrow     <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            borrow <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= {d_bit, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          borrow <= b_bit;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            diff       <= {d_bit, a_sr[WIDTH-1:1]};
            borrow_out <= b_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
